// File: rtl/fft8_twiddle_lut.sv
// ----------------------------------------------------------------------------
// fft8_twiddle_lut
// Twiddle-factor ROM for the radix-2 DIT FFT core.
//   twiddle = {re, im} = round(32767 * (cos(2*pi*n/N) - j*sin(2*pi*n/N)))
// Only a quarter-wave table of N/4+1 sine magnitudes is built. The constants
// are computed at elaboration, so no trig logic or multipliers are generated.
// The other quadrants come from swapping and negating, selected by n[LOG2N-1:LOG2N-2].
// Rounding is to nearest with ties away from zero, and it is symmetric, so
// negating a rounded magnitude gives the same value as the direct formula.
// Addresses n >= N return zero and set a sticky range_err flag.
//
// Optional macro FFT_TWIDDLE_REG_OUT_EN: when defined, twiddle is registered
// and has one cycle of latency. The default build is a combinational lookup.
// ----------------------------------------------------------------------------
module fft8_twiddle_lut #(
  parameter int N  = 8,   // transform size, power of two, 8..1024
  parameter int AW = 10   // address width, 2**AW >= N
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [AW-1:0] n,
  input  logic          err_clr,
  output logic [31:0]   twiddle,
  output logic          range_err
);

  localparam int  LOG2N = $clog2(N);
  localparam int  QW    = LOG2N - 2;   // bits of the offset inside a quadrant
  localparam int  QN    = N / 4;       // quarter-wave table spans 0..QN
  localparam real PI    = 3.14159265358979323846;

  // Quarter-wave sine magnitudes: sin_q[k] = round(32767*sin(2*pi*k/N)).
  // All entries are >= 0, so adding 0.5 and truncating rounds ties away from zero.
  logic [15:0] sin_q [0:QN];

  for (genvar k = 0; k <= QN; k++) begin : g_quarter
    localparam int MAG = $rtoi(32767.0 * $sin(2.0 * PI * k / N) + 0.5);
    // NOTE: the ROM is pure constants, so it needs no reset.
    assign sin_q[k] = MAG[15:0];
  end

  logic               out_of_range;
  logic [1:0]         quad;
  logic [QW-1:0]      offs;
  logic [QW:0]        offs_c;      // complementary offset for the cosine term
  logic signed [15:0] s_sin;
  logic signed [15:0] s_cos;
  logic signed [15:0] re;
  logic signed [15:0] im;
  logic [31:0]        twiddle_c;

  assign out_of_range = (32'(n) >= 32'(N));
  assign quad         = n[LOG2N-1 -: 2];
  assign offs         = n[QW-1:0];
  assign offs_c       = (QW+1)'(QN) - {1'b0, offs};
  assign s_sin        = $signed(sin_q[{1'b0, offs}]);
  assign s_cos        = $signed(sin_q[offs_c]);

  // Quadrant symmetry: theta = quad*90deg + phi, using sin(phi) and cos(phi).
  always_comb begin
    // NOTE: assign defaults first so every path drives re/im and no latch is inferred.
    re = '0;
    im = '0;
    unique case (quad)
      2'd0: begin re =  s_cos; im = -s_sin; end
      2'd1: begin re = -s_sin; im = -s_cos; end
      2'd2: begin re = -s_cos; im =  s_sin; end
      2'd3: begin re =  s_sin; im =  s_cos; end
    endcase
  end

  assign twiddle_c = out_of_range ? 32'h0000_0000 : {re, im};

`ifdef FFT_TWIDDLE_REG_OUT_EN
  // Registered output: one cycle of latency from n, forced to zero in reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      twiddle <= '0;
    end else begin
      twiddle <= twiddle_c;
    end
  end
`else
  assign twiddle = twiddle_c;
`endif

  // Sticky range flag: a bad address sets it and wins over a clear in the same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      range_err <= 1'b0;
    end else if (out_of_range) begin
      // NOTE: state uses non-blocking assignments, so every flop samples pre-edge values.
      range_err <= 1'b1;
    end else if (err_clr) begin
      range_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft8_twiddle_lut.sv
// ----------------------------------------------------------------------------
// tb_fft8_twiddle_lut
// Directed bench for fft8_twiddle_lut. It uses an N=8 instance and an N=1024
// instance. Lookup vectors are table-driven. The range_err and reset corner
// cases are hand-written sequences. The bench follows FFT_TWIDDLE_REG_OUT_EN,
// which adds one cycle of output latency.
// ----------------------------------------------------------------------------
module tb_fft8_twiddle_lut;

  typedef struct {
    logic [9:0]         n;
    logic signed [15:0] re;
    logic signed [15:0] im;
  } vec_t;

  logic        Clk;
  logic        Reset_n;
  logic [9:0]  n8;
  logic [9:0]  n1k;
  logic        err_clr;
  logic [31:0] tw8;
  logic [31:0] tw1k;
  logic        rerr8;
  logic        rerr1k;

  int errors = 0;
  int checks = 0;

  vec_t v8  [11];
  vec_t v1k [10];

  fft8_twiddle_lut #(.N(8), .AW(10)) dut8 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .n         (n8),
    .err_clr   (err_clr),
    .twiddle   (tw8),
    .range_err (rerr8)
  );

  fft8_twiddle_lut #(.N(1024), .AW(10)) dut1k (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .n         (n1k),
    .err_clr   (1'b0),
    .twiddle   (tw1k),
    .range_err (rerr1k)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wait until the twiddle for the newly driven address is visible.
  task automatic settle();
`ifdef FFT_TWIDDLE_REG_OUT_EN
    @(posedge Clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    // N=8 sweep plus out-of-range addresses.
    v8[0]  = '{10'd0,   16'sd32767,  16'sd0};
    v8[1]  = '{10'd1,   16'sd23170, -16'sd23170};
    v8[2]  = '{10'd2,   16'sd0,     -16'sd32767};
    v8[3]  = '{10'd3,  -16'sd23170, -16'sd23170};
    v8[4]  = '{10'd4,  -16'sd32767,  16'sd0};
    v8[5]  = '{10'd5,  -16'sd23170,  16'sd23170};
    v8[6]  = '{10'd6,   16'sd0,      16'sd32767};
    v8[7]  = '{10'd7,   16'sd23170,  16'sd23170};
    v8[8]  = '{10'd8,   16'sd0,      16'sd0};
    v8[9]  = '{10'd9,   16'sd0,      16'sd0};
    v8[10] = '{10'd1023, 16'sd0,     16'sd0};
    // N=1024 spot values.
    v1k[0] = '{10'd0,    16'sd32767,  16'sd0};
    v1k[1] = '{10'd1,    16'sd32766, -16'sd201};
    v1k[2] = '{10'd3,    16'sd32761, -16'sd603};
    v1k[3] = '{10'd128,  16'sd23170, -16'sd23170};
    v1k[4] = '{10'd256,  16'sd0,     -16'sd32767};
    v1k[5] = '{10'd384, -16'sd23170, -16'sd23170};
    v1k[6] = '{10'd512, -16'sd32767,  16'sd0};
    v1k[7] = '{10'd640, -16'sd23170,  16'sd23170};
    v1k[8] = '{10'd768,  16'sd0,      16'sd32767};
    v1k[9] = '{10'd1023, 16'sd32766,  16'sd201};

    // Reset state.
    Reset_n = 1'b0;
    n8      = '0;
    n1k     = '0;
    err_clr = 1'b0;
    #3;
    check("reset_range_err", 32'(rerr8), 32'h0);
`ifdef FFT_TWIDDLE_REG_OUT_EN
    check("reset_twiddle", tw8, 32'h0000_0000);
`else
    check("reset_twiddle", tw8, 32'h7FFF_0000);
`endif
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check("post_reset_range_err", 32'(rerr8), 32'h0);
    check("post_reset_twiddle", tw8, 32'h7FFF_0000);

    // Table-driven lookups.
    for (int i = 0; i < 11; i++) begin
      @(negedge Clk);
      n8 = v8[i].n;
      settle();
      check($sformatf("n8_%0d", v8[i].n), tw8, {v8[i].re, v8[i].im});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      n1k = v1k[i].n;
      settle();
      check($sformatf("n1k_%0d", v1k[i].n), tw1k, {v1k[i].re, v1k[i].im});
    end

    // Out-of-range address for one clock sets the flag.
    @(negedge Clk);
    n8 = 10'd8;
    err_clr = 1'b0;
    @(posedge Clk);
    #1;
    check("oor_set_range_err", 32'(rerr8), 32'h1);
    check("oor_twiddle", tw8, 32'h0000_0000);

    // Clear with an in-range address.
    @(negedge Clk);
    n8 = 10'd2;
    err_clr = 1'b1;
    @(posedge Clk);
    #1;
    check("clear_range_err", 32'(rerr8), 32'h0);
    check("clear_twiddle", tw8, 32'h0000_8001);

    // Set wins over a clear in the same cycle.
    @(negedge Clk);
    n8 = 10'd9;
    err_clr = 1'b1;
    @(posedge Clk);
    #1;
    check("set_wins_range_err", 32'(rerr8), 32'h1);

    // Flag holds with no clear.
    @(negedge Clk);
    n8 = 10'd0;
    err_clr = 1'b0;
    @(posedge Clk);
    #1;
    check("hold_range_err", 32'(rerr8), 32'h1);

    // Reset asserted away from any clock edge clears the flag at once.
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset_range_err", 32'(rerr8), 32'h0);
`ifdef FFT_TWIDDLE_REG_OUT_EN
    check("async_reset_twiddle", tw8, 32'h0000_0000);
`else
    check("async_reset_twiddle", tw8, 32'h7FFF_0000);
`endif
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    check("release_range_err", 32'(rerr8), 32'h0);
    check("n1k_never_out_of_range", 32'(rerr1k), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft8_twiddle_lut.md
Name: fft8_twiddle_lut

Overview:
- Twiddle-factor ROM for the radix-2 DIT FFT core.
- Maps a twiddle address n to W_N^n = cos(2*pi*n/N) - j*sin(2*pi*n/N), scaled by 32767.
- Output is combinational by default, so the FFT datapath sees the twiddle in the same cycle as the address.
- A small clocked section holds a sticky out-of-range error flag.

Parameters:
- N, 8, transform size; power of two, 8..1024. Table covers n = 0..N-1.
- AW, 10, address width; must satisfy 2^AW >= N.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- n  input  AW  twiddle address.
- err_clr  input  1  synchronous clear of range_err.
- twiddle  output  32  packed {re[15:0], im[15:0]}, signed two's complement.
- range_err  output  1  sticky flag: an out-of-range address was presented.

Behaviour:
- One clock (Clk); reset is asynchronous and active-low (Reset_n).
- Lookup, for n < N:
  - re = round(32767*cos(2*pi*n/N)), im = round(-32767*sin(2*pi*n/N)).
  - Round to nearest, ties away from zero.
  - Results are exact in 16 bits; range -32767..32767. -32768 is never produced.
- Required N=8 values, n=0..7 as (re, im):
  - (32767,0), (23170,-23170), (0,-32767), (-23170,-23170)
  - (-32767,0), (-23170,23170), (0,32767), (23170,23170)
- Table construction:
  - Constants precomputed at elaboration, or stored as a quarter-wave table of N/4+1 magnitudes.
  - Remaining octants derived by symmetry, with sign/swap logic on bits n[log2N-1:log2N-2].
  - Outputs must match the direct formula bit-exactly.
  - No runtime trig and no multipliers.
- Out of range (n >= N): twiddle = 32'h0000_0000.
- Timing, without REG_OUT_EN: twiddle is purely combinational from n; no clock dependency, and reset does not affect it.
- range_err:
  - Rising edge of Clk with n >= N sets range_err to 1.
  - err_clr=1 with n < N clears it.
  - If err_clr and an out-of-range n occur in the same cycle, set wins.
  - Otherwise it holds.
- Reset: Reset_n=0 forces range_err=0 immediately (asynchronous). Release is synchronous to the next Clk edge.
- Reset asserted mid-operation: range_err clears; lookup output is unaffected.

Optional Feature:
- Macro: FFT_TWIDDLE_REG_OUT_EN.
- Defined:
  - twiddle is registered on the rising edge of Clk, giving 1-cycle latency from n.
  - Reset_n=0 forces twiddle to 0.
  - range_err evaluates the same-cycle n, unchanged.
  - The FFT controller must pipeline its address by one cycle.
- Undefined: combinational output, zero latency, as specified above.

Test Plan:
- Reset_n=0 then release, with n=0 -> range_err=0, twiddle=32'h7FFF_0000.
- Sweep n=0..7 with N=8 -> the eight listed pairs exactly, e.g. n=1 -> re=23170, im=-23170; n=3 -> re=-23170, im=-23170.
- n=8 for one clock -> twiddle=0 and range_err=1 after the edge; n=2, err_clr=1 -> range_err=0 next edge, twiddle=(0,-32767).
- n=9 with err_clr=1 in the same cycle -> range_err stays 1; assert Reset_n=0 mid-cycle -> range_err drops to 0 without waiting for a clock edge.
- N=1024: n=128 -> (23170,-23170); n=256 -> (0,-32767); n=1 -> (32766,-201).
- FFT_TWIDDLE_REG_OUT_EN defined: apply n=2 -> twiddle=(0,-32767) one edge later, and 0 while in reset.
